// File: rtl/conv_sched_pkg.sv
// Shared types and sizes for the conv_engine scheduler.
package conv_sched_pkg;

  localparam int unsigned ROW_W   = 256;
  localparam int unsigned NUM_REQ = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/conv_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, on contention the one
// that did not own the engine last wins.
module conv_rr_pick
  import conv_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            last_owner,
  output logic               valid,
  output req_id_t            winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last_owner;
    end else if (req[1]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/conv_scheduler.sv
// Arbitrates two row requesters onto a single conv_engine, one run at a time.
// Optional engine watchdog: define CONV_SCHED_TIMEOUT_EN.
module conv_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [ROW_W-1:0]   row_data0,
  input  logic [ROW_W-1:0]   row_data1,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] timeout,
  output logic               busy,
  output req_id_t            owner,
  output logic [CNT_W-1:0]   done_cnt0,
  output logic [CNT_W-1:0]   done_cnt1,
  output logic               eng_start,
  output logic [ROW_W-1:0]   eng_pixel_row_data,
  input  logic               eng_done
);

  state_t             state, state_nxt;
  req_id_t            last_owner, last_owner_nxt;
  req_id_t            owner_nxt;
  logic [NUM_REQ-1:0] gnt_nxt, done_nxt;
  logic               start_nxt;
  logic [ROW_W-1:0]   row_nxt;
  logic [CNT_W-1:0]   cnt0_nxt, cnt1_nxt;
  logic               pick_valid;
  req_id_t            pick_winner;

  conv_rr_pick u_pick (
    .req        (req),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

`ifdef CONV_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
  logic [NUM_REQ-1:0] timeout_nxt;
`endif

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      last_owner         <= 1'b1;
      owner              <= 1'b0;
      gnt                <= '0;
      done               <= '0;
      eng_start          <= 1'b0;
      busy               <= 1'b0;
      eng_pixel_row_data <= '0;
      done_cnt0          <= '0;
      done_cnt1          <= '0;
    end else begin
      state              <= state_nxt;
      last_owner         <= last_owner_nxt;
      owner              <= owner_nxt;
      gnt                <= gnt_nxt;
      done               <= done_nxt;
      eng_start          <= start_nxt;
      busy               <= (state_nxt == ST_BUSY);
      eng_pixel_row_data <= row_nxt;
      done_cnt0          <= cnt0_nxt;
      done_cnt1          <= cnt1_nxt;
    end
  end

`ifdef CONV_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      timeout <= '0;
    end else begin
      tmo_cnt <= tmo_cnt_nxt;
      timeout <= timeout_nxt;
    end
  end
`else
  assign timeout = '0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    owner_nxt      = owner;
    gnt_nxt        = '0;
    done_nxt       = '0;
    start_nxt      = 1'b0;
    row_nxt        = eng_pixel_row_data;
    cnt0_nxt       = done_cnt0;
    cnt1_nxt       = done_cnt1;
`ifdef CONV_SCHED_TIMEOUT_EN
    tmo_cnt_nxt    = tmo_cnt;
    timeout_nxt    = '0;
`endif
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt            = ST_BUSY;
          owner_nxt            = pick_winner;
          last_owner_nxt       = pick_winner;
          row_nxt              = pick_winner ? row_data1 : row_data0;
          gnt_nxt[pick_winner] = 1'b1;
          start_nxt            = 1'b1;
`ifdef CONV_SCHED_TIMEOUT_EN
          tmo_cnt_nxt          = '0;
`endif
        end
      end
      ST_BUSY: begin
        // eng_done takes priority over a watchdog expiring in the same cycle
        if (eng_done) begin
          state_nxt       = ST_IDLE;
          done_nxt[owner] = 1'b1;
          if (owner) begin
            cnt1_nxt = done_cnt1 + CNT_W'(1);
          end else begin
            cnt0_nxt = done_cnt0 + CNT_W'(1);
          end
        end
`ifdef CONV_SCHED_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES)) begin
          state_nxt          = ST_IDLE;
          timeout_nxt[owner] = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_scheduler.sv
// Self-checking bench for conv_scheduler: directed scenarios plus a random
// phase, all compared each cycle against a transaction-level reference model.
module tb_conv_scheduler;
  import conv_sched_pkg::*;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TMO   = 20;
`ifdef CONV_SCHED_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [ROW_W-1:0] row_data0, row_data1;
  logic [1:0]       gnt, done, timeout;
  logic             busy, owner, eng_start, eng_done;
  logic [CNT_W-1:0] done_cnt0, done_cnt1;
  logic [ROW_W-1:0] eng_pixel_row_data;

  int checks = 0;
  int errors = 0;

  conv_scheduler #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                (clk),
    .rst                (rst),
    .req                (req),
    .row_data0          (row_data0),
    .row_data1          (row_data1),
    .gnt                (gnt),
    .done               (done),
    .timeout            (timeout),
    .busy               (busy),
    .owner              (owner),
    .done_cnt0          (done_cnt0),
    .done_cnt1          (done_cnt1),
    .eng_start          (eng_start),
    .eng_pixel_row_data (eng_pixel_row_data),
    .eng_done           (eng_done)
  );

  always #5 clk = ~clk;

  // Reference model: one engine, at most one outstanding run
  bit               m_busy;
  int               m_owner, m_last, m_wait;
  int               m_cnt [2];
  logic [ROW_W-1:0] m_row;
  logic [1:0]       m_gnt, m_done, m_tmo;
  bit               m_start;

  // Simple engine and requester helpers
  bit eng_armed = 1'b0;
  bit eng_mute  = 1'b0;
  int eng_timer = 0;
  int eng_lat   = 10;

  function automatic int pick(input logic [1:0] r, input int last);
    if (r == 2'b11) return 1 - last;
    return r[1] ? 1 : 0;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < int'(ROW_W / 32); i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    int w;
    m_gnt = '0; m_done = '0; m_tmo = '0; m_start = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_last = 1; m_wait = 0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_row = '0;
    end else if (!m_busy) begin
      if (req != 2'b00) begin
        w = pick(req, m_last);
        m_owner = w; m_last = w;
        m_row = (w == 1) ? row_data1 : row_data0;
        m_gnt[w] = 1'b1; m_start = 1'b1; m_busy = 1'b1; m_wait = 0;
      end
    end else if (eng_done) begin
      m_done[m_owner] = 1'b1;
      m_cnt[m_owner] = (m_cnt[m_owner] + 1) % 65536;
      m_busy = 1'b0;
    end else if (TMO_EN && m_wait == int'(TMO)) begin
      m_tmo[m_owner] = 1'b1;
      m_busy = 1'b0;
    end else begin
      m_wait++;
    end
  endtask

  task automatic check_all();
    chk("gnt", ROW_W'(gnt), ROW_W'(m_gnt));
    chk("done", ROW_W'(done), ROW_W'(m_done));
    chk("timeout", ROW_W'(timeout), ROW_W'(m_tmo));
    chk("busy", ROW_W'(busy), ROW_W'(m_busy));
    chk("owner", ROW_W'(owner), ROW_W'(m_owner));
    chk("eng_start", ROW_W'(eng_start), ROW_W'(m_start));
    chk("done_cnt0", ROW_W'(done_cnt0), ROW_W'(m_cnt[0]));
    chk("done_cnt1", ROW_W'(done_cnt1), ROW_W'(m_cnt[1]));
    chk("row", eng_pixel_row_data, m_row);
  endtask

  task automatic engine_update();
    eng_done = 1'b0;
    if (rst) begin
      eng_armed = 1'b0;
    end else begin
      if (eng_start && !eng_mute) begin
        eng_armed = 1'b1;
        eng_timer = eng_lat;
      end
      if (eng_armed) begin
        if (eng_timer == 0) begin
          eng_done  = 1'b1;
          eng_armed = 1'b0;
        end else begin
          eng_timer--;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
    engine_update();
  endtask

  task automatic step_until_gnt(input int i, input int max);
    int n = 0;
    do begin
      step();
      n++;
    end while (!gnt[i] && n < max);
    chk("gnt_wait", ROW_W'(gnt[i]), ROW_W'(1'b1));
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      step();
      n++;
    end
    chk("wait_idle", ROW_W'(busy), ROW_W'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [$];
    int tmo_seen, done_seen;
    logic [ROW_W-1:0] r0;

    rst = 1'b1; req = 2'b00; eng_done = 1'b0;
    row_data0 = rand_row(); row_data1 = rand_row();
    repeat (3) step();
    chk("rst_busy", ROW_W'(busy), ROW_W'(1'b0));
    chk("rst_row", eng_pixel_row_data, ROW_W'(0));
    rst = 1'b0;
    step();

    // Single request, engine latency 10
    r0 = row_data0;
    eng_lat = 10;
    req = 2'b01;
    step_until_gnt(0, 5);
    chk("single_start", ROW_W'(eng_start), ROW_W'(1'b1));
    chk("single_row", eng_pixel_row_data, r0);
    req = 2'b00;
    wait_idle(30);
    chk("single_cnt0", ROW_W'(done_cnt0), ROW_W'(1));

    // Contention from a fresh reset: grants alternate starting with 0
    rst = 1'b1; step(); rst = 1'b0;
    eng_lat = 3;
    req = 2'b11;
    for (int n = 0; n < 60 && order.size() < 4; n++) begin
      step();
      if (gnt[0]) order.push_back(0);
      if (gnt[1]) order.push_back(1);
    end
    req = 2'b00;
    wait_idle(20);
    chk("cont_grants", ROW_W'(order.size()), ROW_W'(4));
    foreach (order[i]) chk("cont_order", ROW_W'(order[i]), ROW_W'(i % 2));
    chk("cont_cnt0", ROW_W'(done_cnt0), ROW_W'(2));
    chk("cont_cnt1", ROW_W'(done_cnt1), ROW_W'(2));

    // Spurious eng_done while idle
    step();
    eng_done = 1'b1;
    step();
    step();
    chk("spur_busy", ROW_W'(busy), ROW_W'(1'b0));
    chk("spur_done", ROW_W'(done), ROW_W'(0));
    chk("spur_cnt0", ROW_W'(done_cnt0), ROW_W'(2));

    // Requester 1 raises and drops while requester 0 is running
    eng_lat = 8;
    req = 2'b01;
    step_until_gnt(0, 5);
    req = 2'b00;
    repeat (2) step();
    req = 2'b10;
    repeat (2) step();
    req = 2'b00;
    wait_idle(20);
    repeat (3) begin
      step();
      chk("drop_nognt", ROW_W'(gnt), ROW_W'(0));
    end
    chk("drop_busy", ROW_W'(busy), ROW_W'(1'b0));
    chk("drop_cnt1", ROW_W'(done_cnt1), ROW_W'(2));

    // Engine never answers
    eng_mute = 1'b1;
    req = 2'b01;
    step_until_gnt(0, 5);
    req = 2'b00;
    tmo_seen = 0; done_seen = 0;
    repeat (30) begin
      step();
      if (timeout[0]) tmo_seen++;
      if (done != 2'b00) done_seen++;
    end
    chk("tmo_done", ROW_W'(done_seen), ROW_W'(0));
    if (TMO_EN) begin
      chk("tmo_pulses", ROW_W'(tmo_seen), ROW_W'(1));
      chk("tmo_busy", ROW_W'(busy), ROW_W'(1'b0));
      eng_done = 1'b1;
      step();
      step();
      chk("late_done", ROW_W'(done), ROW_W'(0));
      chk("late_cnt0", ROW_W'(done_cnt0), ROW_W'(3));
    end else begin
      chk("tmo_pulses", ROW_W'(tmo_seen), ROW_W'(0));
      chk("stuck_busy", ROW_W'(busy), ROW_W'(1'b1));
    end
    eng_mute = 1'b0;

    // Reset in the middle of a run
    rst = 1'b1; step(); rst = 1'b0;
    eng_lat = 20;
    req = 2'b01;
    step_until_gnt(0, 5);
    req = 2'b00;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("mid_rst_busy", ROW_W'(busy), ROW_W'(1'b0));
    chk("mid_rst_cnt0", ROW_W'(done_cnt0), ROW_W'(0));
    chk("mid_rst_row", eng_pixel_row_data, ROW_W'(0));
    rst = 1'b0;
    req = 2'b10;
    step();
    chk("post_rst_gnt", ROW_W'(gnt), ROW_W'(2'b10));
    chk("post_rst_start", ROW_W'(eng_start), ROW_W'(1'b1));
    req = 2'b00;
    wait_idle(30);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (!eng_armed) eng_lat = $urandom_range(0, 5);
      step();
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          if (gnt[i]) req[i] = ($urandom_range(0, 3) == 0);
          else if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          if (i == 0) row_data0 = rand_row();
          else        row_data1 = rand_row();
        end
      end
      if (!eng_armed && $urandom_range(0, 15) == 0) eng_done = 1'b1;
    end
    rst = 1'b0;
    req = 2'b00;
    wait_idle(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_scheduler.md
# conv_scheduler

Shares the single `conv_engine` between two row requesters: requester 0 is the near-field lane row and requester 1 is the far-field row. The block arbitrates round-robin, latches the granted 32-pixel row, and sequences one engine run at a time. It then routes the engine's completion pulse back to the owning requester. It sits between the requesters (each a `top_controller`-style lane tracker) and the engine. Result data fans out from the engine to both requesters directly; `done[i]` qualifies which requester owns it.

## Interface
- `ROW_W`, 256: flattened row width, 32 pixels × 8 bits.
- `CNT_W`, 16: width of each per-requester completion counter.
- `TIMEOUT_CYCLES`, 255: engine watchdog limit in cycles. Used only with `CONV_SCHED_TIMEOUT_EN`.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req` in 2: `req[i]` asks for one engine run. It is held until `gnt[i]`.
- `row_data0` in ROW_W: requester 0 row, valid while `req[0]` is high.
- `row_data1` in ROW_W: requester 1 row, valid while `req[1]` is high.
- `gnt` out 2: one-cycle pulse when the row is accepted.
- `done` out 2: one-cycle pulse; engine results are valid for that requester.
- `timeout` out 2: one-cycle pulse when the owner's run was abandoned.
- `busy` out 1: high while a run is outstanding.
- `owner` out 1: index of the current or last granted requester.
- `done_cnt0` out CNT_W: completed runs for requester 0; wraps.
- `done_cnt1` out CNT_W: completed runs for requester 1; wraps.
- `eng_start` out 1: one-cycle start pulse to the engine.
- `eng_pixel_row_data` out ROW_W: latched row, stable from grant until the next grant.
- `eng_done` in 1: engine completion pulse.

## Operation
- FSM states are IDLE and BUSY.
- IDLE, no `req`: stay in IDLE.
- IDLE, any `req` bit set: pick a winner, latch its row into `eng_pixel_row_data`, set `owner`, pulse `gnt[owner]` and `eng_start`, update `last_owner`, and go to BUSY.
- BUSY, `eng_done` high: pulse `done[owner]`, increment that requester's counter (wraps to 0 after the maximum), and go to IDLE.
- Arbitration with one request: the requester that asks wins.
- Arbitration with both requesting: the requester that is not `last_owner` wins.
- `last_owner` resets to 1, so requester 0 wins the first contention.
- `req` is ignored in BUSY. A requester that drops `req` before its grant is simply not served; there is no queue.
- `eng_done` in IDLE (spurious or late) is ignored: no `done`, no count.
- At most one run is outstanding.
- `busy` = (state == BUSY).

## Timing
- Reset values:
  - state IDLE
  - `gnt`, `done`, `timeout`, `eng_start`: 0
  - `busy`: 0
  - `owner`: 0, `last_owner`: 1
  - `eng_pixel_row_data`: 0
  - both counters: 0
- All outputs are registered.
- Grant timing: `req` sampled in IDLE at cycle N gives `gnt` + `eng_start` high in cycle N+1, with the row already on `eng_pixel_row_data`.
- Completion timing: `eng_done` in cycle M (BUSY) gives `done[owner]` in cycle M+1; the counter updates at the same edge.
- Back-to-back: state is IDLE in M+1, so a pending `req` in M+1 produces the next grant in M+2. The minimum issue interval is therefore engine latency + 2.
- `eng_done` in the first BUSY cycle (the cycle of `eng_start`) is accepted.
- Reset asserted mid-run: the run is dropped, and no `done` or `timeout` is produced.

## Configuration
- `CONV_SCHED_TIMEOUT_EN` defined:
  - In BUSY, a counter clears at grant and increments each cycle without `eng_done`.
  - When the count reaches `TIMEOUT_CYCLES`, the next cycle pulses `timeout[owner]`, the FSM returns to IDLE, and the counter is not incremented.
  - If `eng_done` arrives in the same cycle the limit is reached, `eng_done` wins.
- Not defined: BUSY waits indefinitely, `timeout` is tied to 0, and no counter is synthesized.

## Structure
- Package `conv_sched_pkg` holds:
  - `ROW_W`
  - `NUM_REQ` = 2
  - the FSM state enum
  - a `req_id_t` typedef (1 bit)
- Sub-module `conv_rr_pick` is combinational. Inputs are `req[1:0]` and `last_owner`; outputs are `valid` and `winner`.
- The FSM, latches and counters live in `conv_scheduler`.

## Test plan
- Single request, engine done after 10 cycles:
  - `req=01` → `gnt=01` and `eng_start` one cycle later, row0 on the engine bus.
  - `done=01` one cycle after `eng_done`; `done_cnt0=1`.
- Contention: `req=11` held continuously across 4 runs → grants alternate 0,1,0,1; `done_cnt0=done_cnt1=2`.
- Spurious done: `eng_done` pulsed in IDLE → no `done`, counters unchanged, FSM stays in IDLE.
- Request dropped in BUSY: `req[1]` raised and dropped while requester 0's run is in flight → after completion no grant to requester 1, and `busy=0`.
- Timeout (macro on, `TIMEOUT_CYCLES`=20):
  - Withhold `eng_done` → `timeout[owner]` pulses once, FSM returns to IDLE, no `done`.
  - A late `eng_done` afterwards is ignored.
  - With the macro off, the same stimulus leaves `busy=1`.
- Reset mid-BUSY: all outputs return to their reset values; the next `req=10` is granted to requester 1 on the following cycle.
